// File: rtl/fifo_operand_reader.sv
// fifo_operand_reader: drains NWORDS FIFO words into one packed operand on a valid/ready port.
// Define FIFO_READER_MSW_FIRST_EN to pack the first word read into the most significant slot.
module fifo_operand_reader #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [WIDTH-1:0]          fifo_rd_data,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [WIDTH*NWORDS-1:0]   op_data,
    output logic                      busy
);
    localparam int CW = $clog2(NWORDS + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           received_q, received_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [WIDTH*NWORDS-1:0] op_data_q, op_data_d;
    logic [CW-1:0]           slot;
    logic                    last_capture;
    logic                    handshake;

`ifdef FIFO_READER_MSW_FIRST_EN
    assign slot = CW'(NWORDS - 1) - received_q;
`else
    assign slot = received_q;
`endif

    assign last_capture = rd_pend_q && (received_q == CW'(NWORDS - 1));
    assign handshake    = op_valid && op_ready;

    // state register and datapath flops; reset discards any partial operand and in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            issued_q   <= '0;
            received_q <= '0;
            rd_pend_q  <= 1'b0;
            op_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            rd_pend_q  <= rd_pend_d;
            op_data_q  <= op_data_d;
        end
    end

    // next state: the final capture completes the operand, the handshake releases it
    always_comb begin
        state_d = (state_q == FILL) ? (last_capture ? HOLD : FILL) : (op_ready ? FILL : HOLD);
    end

    // outputs, counters and word capture into the slot chosen by the receive count
    always_comb begin
        fifo_rd_en = (state_q == FILL) && !fifo_empty && (issued_q < CW'(NWORDS));
        busy       = (state_q == FILL) && (issued_q != '0);
        op_valid   = (state_q == HOLD);
        op_data    = op_data_q;
        rd_pend_d  = fifo_rd_en;
        issued_d   = handshake ? '0 : issued_q + CW'(fifo_rd_en);
        received_d = handshake ? '0 : received_q + CW'(rd_pend_q);
        op_data_d  = op_data_q;
        for (int i = 0; i < NWORDS; i++)
            if (rd_pend_q && slot == CW'(i))
                op_data_d[i*WIDTH +: WIDTH] = fifo_rd_data;
    end
endmodule
